// File: rtl/btn_pulse_pkg.sv
// Shared definitions for the button/switch pulse conditioner: edge-mode
// encodings, event counter width and the counter-width helper.
package btn_pulse_pkg;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'b00,
        MODE_RISE = 2'b01,
        MODE_FALL = 2'b10,
        MODE_BOTH = 2'b11
    } btn_mode_e;

    localparam int unsigned EVENT_W = 16;

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/btn_pulse_ctrl_if.sv
// Board-side bundle of btn_pulse_ctrl: raw levels and controls in,
// conditioned levels, command pulses and event count out.
interface btn_pulse_ctrl_if #(
    parameter int unsigned CHANNELS = 3
);
    import btn_pulse_pkg::*;

    logic [CHANNELS-1:0]   raw_in;
    logic [2*CHANNELS-1:0] mode;
    logic [CHANNELS-1:0]   repeat_en;
    logic                  count_clr;
    logic [CHANNELS-1:0]   level;
    logic [CHANNELS-1:0]   pulse;
    logic                  any_pulse;
    logic [EVENT_W-1:0]    event_count;

    modport master (
        output raw_in, mode, repeat_en, count_clr,
        input  level, pulse, any_pulse, event_count
    );

    modport slave (
        input  raw_in, mode, repeat_en, count_clr,
        output level, pulse, any_pulse, event_count
    );

endinterface

// File: rtl/btn_pulse_chan.sv
// One input channel: synchroniser, debounce, edge-mode pulse and auto-repeat,
// with level and pulse both registered so they change on the same edge.
module btn_pulse_chan
    import btn_pulse_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned REPEAT_DELAY    = 1000,
    parameter int unsigned REPEAT_PERIOD   = 250
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_raw,
    input  logic [1:0] i_mode,
    input  logic       i_repeat_en,
    output logic       o_level,
    output logic       o_pulse
);

    localparam int unsigned DW   = cnt_width(DEBOUNCE_CYCLES);
    localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RW   = cnt_width(RMAX);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [DW-1:0]          r_cnt;
    logic [RW-1:0]          r_rep;
    logic                   r_level;
    logic                   r_pulse;

    btn_mode_e w_mode;
    logic      w_s;
    logic      w_toggle;
    logic      w_rise_en;
    logic      w_fall_en;
    logic      w_edge_hit;
    logic      w_rep_ok;
    logic      w_press;
    logic      w_rep_fire;

    assign w_mode     = btn_mode_e'(i_mode);
    assign w_s        = r_sync[SYNC_STAGES-1];
    assign w_rise_en  = (w_mode == MODE_RISE) || (w_mode == MODE_BOTH);
    assign w_fall_en  = (w_mode == MODE_FALL) || (w_mode == MODE_BOTH);
    // The level flips once the mismatch has been seen DEBOUNCE_CYCLES+1 times;
    // with DEBOUNCE_CYCLES=0 this degenerates to a plain copy of w_s.
    assign w_toggle   = (w_s != r_level) && (r_cnt == DW'(DEBOUNCE_CYCLES));
    assign w_edge_hit = w_toggle && (r_level ? w_fall_en : w_rise_en);
    assign w_rep_ok   = i_repeat_en && w_rise_en;
    assign w_press    = w_toggle && !r_level && w_rep_ok;
    assign w_rep_fire = w_rep_ok && r_level && !w_toggle && (r_rep == RW'(1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync  <= '0;
            r_cnt   <= '0;
            r_rep   <= '0;
            r_level <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_sync[0] <= i_raw;
            for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end

            if (w_s == r_level) begin
                r_cnt <= '0;
            end else if (w_toggle) begin
                r_level <= ~r_level;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + DW'(1);
            end

            // Zero means idle: only a fresh press can arm the repeat timer.
            if (w_press) begin
                r_rep <= RW'(REPEAT_DELAY);
            end else if (!w_rep_ok || !r_level || w_toggle) begin
                r_rep <= '0;
            end else if (w_rep_fire) begin
                r_rep <= RW'(REPEAT_PERIOD);
            end else if (r_rep != '0) begin
                r_rep <= r_rep - RW'(1);
            end

            r_pulse <= w_edge_hit || w_rep_fire;
        end
    end

    assign o_level = r_level;
    assign o_pulse = r_pulse;

endmodule

// File: rtl/btn_pulse_ctrl.sv
// Multi-channel run-control input conditioner: per-channel pulse generators,
// combined pulse flag and a saturating count of pulse cycles.
module btn_pulse_ctrl
    import btn_pulse_pkg::*;
#(
    parameter int unsigned CHANNELS        = 3,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned REPEAT_DELAY    = 1000,
    parameter int unsigned REPEAT_PERIOD   = 250
) (
    input  logic             clock,
    input  logic             reset_n,
    btn_pulse_ctrl_if.slave  bus
);

    logic [CHANNELS-1:0] w_level;
    logic [CHANNELS-1:0] w_pulse;
    logic                w_any;
    logic [EVENT_W-1:0]  r_count;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        btn_pulse_chan #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_chan (
            .i_clk       (clock),
            .i_rst_n     (reset_n),
            .i_raw       (bus.raw_in[g]),
            .i_mode      (bus.mode[2*g+1:2*g]),
            .i_repeat_en (bus.repeat_en[g]),
            .o_level     (w_level[g]),
            .o_pulse     (w_pulse[g])
        );
    end

    assign w_any = |w_pulse;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (bus.count_clr) begin
            r_count <= '0;
        end else if (w_any && (r_count != '1)) begin
            r_count <= r_count + EVENT_W'(1);
        end
    end

    assign bus.level       = w_level;
    assign bus.pulse       = w_pulse;
    assign bus.any_pulse   = w_any;
    assign bus.event_count = r_count;

endmodule

// File: tb/tb_btn_pulse_ctrl.sv
// Bench for btn_pulse_ctrl: directed scenarios plus randomized traffic against
// a sample-history reference model of the conditioner.
module tb_btn_pulse_ctrl;
    import btn_pulse_pkg::*;

    localparam int CH   = 3;
    localparam int SYNC = 2;
    localparam int DEB  = 16;
    localparam int RD   = 20;
    localparam int RP   = 5;
    localparam int LAT  = SYNC + DEB;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    btn_pulse_ctrl_if #(.CHANNELS(CH)) bus ();

    btn_pulse_ctrl #(
        .CHANNELS        (CH),
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: raw sample history per channel, level accepted once the
    // last DEB+1 synchronised samples all disagree with it.
    bit        hist [CH][SYNC+DEB];
    bit [CH-1:0] m_level;
    bit [CH-1:0] m_pulse;
    bit        m_armed [CH];
    int        m_press [CH];
    bit [15:0] m_count;
    int        cyc;

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            for (int k = 0; k < SYNC + DEB; k++) hist[c][k] = 1'b0;
            m_armed[c] = 1'b0;
            m_press[c] = 0;
        end
        m_level = '0;
        m_pulse = '0;
        m_count = '0;
        cyc     = 0;
    endtask

    task automatic model_step();
        bit any_prev, tog, rep_ok, np, newl;
        any_prev = |m_pulse;
        cyc++;
        for (int c = 0; c < CH; c++) begin
            tog = 1'b1;
            for (int j = 0; j <= DEB; j++) if (hist[c][SYNC-1+j] == m_level[c]) tog = 1'b0;
            rep_ok = bus.repeat_en[c] && bus.mode[2*c];
            np = 1'b0;
            if (tog) begin
                newl       = !m_level[c];
                np         = newl ? bus.mode[2*c] : bus.mode[2*c+1];
                m_armed[c] = newl && rep_ok;
                m_press[c] = cyc;
                m_level[c] = newl;
            end else if (!(rep_ok && m_level[c])) begin
                m_armed[c] = 1'b0;
            end else if (m_armed[c] && (cyc - m_press[c] >= RD) && ((cyc - m_press[c] - RD) % RP == 0)) begin
                np = 1'b1;
            end
            m_pulse[c] = np;
            for (int k = SYNC + DEB - 1; k > 0; k--) hist[c][k] = hist[c][k-1];
            hist[c][0] = bus.raw_in[c];
        end
        if (bus.count_clr) m_count = '0;
        else if (any_prev && m_count != 16'hFFFF) m_count = m_count + 16'd1;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step();
        #1;
    endtask

    task automatic set_reset(input logic v);
        rst_n = v;
        if (!v) model_reset();
    endtask

    task automatic test_reset();
        bus.raw_in = '0; bus.mode = '0; bus.repeat_en = '0; bus.count_clr = 1'b0;
        set_reset(1'b0);
        repeat (3) tick();
        n_cmp++;
        if ({bus.level, bus.pulse, bus.any_pulse, bus.event_count} !== 23'd0) begin
            n_err++; $display("FAIL reset_hold: got %h expected 0", {bus.level, bus.pulse, bus.any_pulse, bus.event_count});
        end
        set_reset(1'b1);
        tick();
        n_cmp++;
        if ({bus.level, bus.pulse, bus.any_pulse, bus.event_count} !== 23'd0) begin
            n_err++; $display("FAIL reset_release: got %h expected 0", {bus.level, bus.pulse, bus.any_pulse, bus.event_count});
        end
    endtask

    task automatic test_press_latency();
        int first_p = -1, first_l = -1, np = 0;
        bus.mode   = 6'b010101;
        bus.raw_in = 3'b001;
        for (int k = 0; k < 80; k++) begin
            if (k == 40) bus.raw_in = 3'b000;
            tick();
            n_cmp++;
            if ({bus.level, bus.pulse, bus.any_pulse, bus.event_count} !== {m_level, m_pulse, |m_pulse, m_count}) begin
                n_err++; $display("FAIL model_latency k=%0d: got %h expected %h", k, {bus.level, bus.pulse, bus.any_pulse, bus.event_count}, {m_level, m_pulse, |m_pulse, m_count});
            end
            if (bus.pulse[0]) begin np++; if (first_p < 0) first_p = k; end
            if (bus.level[0] && first_l < 0) first_l = k;
        end
        n_cmp++; if (first_p != LAT) begin n_err++; $display("FAIL press_latency: got edge %0d expected %0d", first_p, LAT); end
        n_cmp++; if (first_l != LAT) begin n_err++; $display("FAIL level_latency: got edge %0d expected %0d", first_l, LAT); end
        n_cmp++; if (np != 1) begin n_err++; $display("FAIL pulse_once: got %0d pulse cycles expected 1", np); end
        n_cmp++; if (bus.event_count !== 16'd1) begin n_err++; $display("FAIL event_count_1: got %0d expected 1", bus.event_count); end
        n_cmp++; if (bus.level[0] !== 1'b0) begin n_err++; $display("FAIL release_level: got %b expected 0", bus.level[0]); end
    endtask

    task automatic test_glitch();
        int lens [3] = '{10, 16, 17};
        bus.mode = 6'b011101;
        foreach (lens[i]) begin
            int np = 0, exp_np;
            bit seen_high = 1'b0;
            logic [15:0] c0 = bus.event_count;
            exp_np = (lens[i] > DEB) ? 2 : 0;
            bus.raw_in = 3'b010;
            for (int k = 0; k < lens[i] + 50; k++) begin
                if (k == lens[i]) bus.raw_in = 3'b000;
                tick();
                n_cmp++;
                if ({bus.level, bus.pulse, bus.any_pulse, bus.event_count} !== {m_level, m_pulse, |m_pulse, m_count}) begin
                    n_err++; $display("FAIL model_glitch len=%0d k=%0d: got %h expected %h", lens[i], k, {bus.level, bus.pulse, bus.any_pulse, bus.event_count}, {m_level, m_pulse, |m_pulse, m_count});
                end
                if (bus.pulse[1]) np++;
                if (bus.level[1]) seen_high = 1'b1;
            end
            n_cmp++; if (np != exp_np) begin n_err++; $display("FAIL glitch_pulses len=%0d: got %0d expected %0d", lens[i], np, exp_np); end
            n_cmp++; if (seen_high != (lens[i] > DEB)) begin n_err++; $display("FAIL glitch_level len=%0d: got %b expected %b", lens[i], seen_high, lens[i] > DEB); end
            n_cmp++; if (bus.event_count - c0 !== 16'(exp_np)) begin n_err++; $display("FAIL glitch_count len=%0d: got +%0d expected +%0d", lens[i], bus.event_count - c0, exp_np); end
        end
    endtask

    task automatic test_repeat();
        bit found = 1'b0, exp_p;
        bus.mode = 6'b010101; bus.repeat_en = 3'b100; bus.raw_in = 3'b100;
        for (int k = 0; k < 40 && !found; k++) begin
            tick();
            if (bus.pulse[2]) found = 1'b1;
        end
        n_cmp++; if (!found) begin n_err++; $display("FAIL repeat_press: got no press pulse expected one within 40 cycles"); end
        for (int k = 1; k <= 50; k++) begin
            tick();
            exp_p = (k >= RD) && ((k - RD) % RP == 0);
            n_cmp++;
            if (bus.pulse[2] !== exp_p) begin n_err++; $display("FAIL repeat_k%0d: got %b expected %b", k, bus.pulse[2], exp_p); end
            n_cmp++;
            if ({bus.level, bus.pulse, bus.any_pulse, bus.event_count} !== {m_level, m_pulse, |m_pulse, m_count}) begin
                n_err++; $display("FAIL model_repeat k=%0d: got %h expected %h", k, {bus.level, bus.pulse, bus.any_pulse, bus.event_count}, {m_level, m_pulse, |m_pulse, m_count});
            end
        end
        bus.repeat_en = 3'b000;
        repeat (3) tick();
        bus.repeat_en = 3'b100;
        for (int k = 0; k < 30; k++) begin
            tick();
            n_cmp++; if (bus.pulse[2] !== 1'b0) begin n_err++; $display("FAIL reenable_no_pulse k=%0d: got 1 expected 0", k); end
        end
        bus.raw_in = 3'b000;
        found = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            tick();
            n_cmp++;
            if ({bus.level, bus.pulse, bus.any_pulse, bus.event_count} !== {m_level, m_pulse, |m_pulse, m_count}) begin
                n_err++; $display("FAIL model_release k=%0d: got %h expected %h", k, {bus.level, bus.pulse, bus.any_pulse, bus.event_count}, {m_level, m_pulse, |m_pulse, m_count});
            end
            if (!bus.level[2]) found = 1'b1;
        end
        n_cmp++; if (!found) begin n_err++; $display("FAIL repeat_release: got level 1 expected 0 within 60 cycles"); end
        for (int k = 0; k < 30; k++) begin
            tick();
            n_cmp++; if (bus.pulse[2] !== 1'b0) begin n_err++; $display("FAIL after_release k=%0d: got 1 expected 0", k); end
        end
        bus.repeat_en = 3'b000;
    endtask

    task automatic test_simultaneous();
        bit found = 1'b0;
        logic [15:0] c0 = bus.event_count;
        bus.mode = 6'b010101; bus.raw_in = 3'b011;
        for (int k = 0; k < 40 && !found; k++) begin tick(); if (bus.pulse != 3'b000) found = 1'b1; end
        n_cmp++; if (bus.pulse !== 3'b011) begin n_err++; $display("FAIL simul_pulse: got %b expected 011", bus.pulse); end
        n_cmp++; if (bus.any_pulse !== 1'b1) begin n_err++; $display("FAIL simul_any: got %b expected 1", bus.any_pulse); end
        tick();
        n_cmp++; if (bus.event_count !== c0 + 16'd1) begin n_err++; $display("FAIL simul_count: got %0d expected %0d", bus.event_count, c0 + 16'd1); end
        n_cmp++; if (bus.pulse !== 3'b000) begin n_err++; $display("FAIL simul_width: got %b expected 000", bus.pulse); end
        bus.raw_in = 3'b000;
        repeat (40) tick();
        bus.raw_in = 3'b001;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin tick(); if (bus.pulse[0]) found = 1'b1; end
        n_cmp++; if (!found) begin n_err++; $display("FAIL clr_press: got no pulse expected one within 40 cycles"); end
        bus.count_clr = 1'b1;
        tick();
        bus.count_clr = 1'b0;
        n_cmp++; if (bus.event_count !== 16'd0) begin n_err++; $display("FAIL clr_wins: got %0d expected 0", bus.event_count); end
        bus.raw_in = 3'b000;
        repeat (40) tick();
    endtask

    task automatic test_reset_mid();
        logic [5:0] modes [2] = '{6'b010101, 6'b010100};
        foreach (modes[v]) begin
            int first_p = -1, np = 0, exp_first;
            exp_first = (v == 0) ? LAT : -1;
            bus.mode = modes[v]; bus.raw_in = 3'b001;
            repeat (12) tick();
            set_reset(1'b0);
            #1;
            n_cmp++;
            if ({bus.level, bus.pulse, bus.any_pulse, bus.event_count} !== 23'd0) begin
                n_err++; $display("FAIL reset_async v=%0d: got %h expected 0", v, {bus.level, bus.pulse, bus.any_pulse, bus.event_count});
            end
            tick();
            set_reset(1'b1);
            for (int k = 0; k < 40; k++) begin
                tick();
                n_cmp++;
                if ({bus.level, bus.pulse, bus.any_pulse, bus.event_count} !== {m_level, m_pulse, |m_pulse, m_count}) begin
                    n_err++; $display("FAIL model_rstmid v=%0d k=%0d: got %h expected %h", v, k, {bus.level, bus.pulse, bus.any_pulse, bus.event_count}, {m_level, m_pulse, |m_pulse, m_count});
                end
                if (bus.pulse[0]) begin np++; if (first_p < 0) first_p = k; end
            end
            n_cmp++; if (first_p != exp_first) begin n_err++; $display("FAIL rstmid_latency v=%0d: got %0d expected %0d", v, first_p, exp_first); end
            n_cmp++; if (np != ((v == 0) ? 1 : 0)) begin n_err++; $display("FAIL rstmid_pulses v=%0d: got %0d expected %0d", v, np, (v == 0) ? 1 : 0); end
            n_cmp++; if (bus.level[0] !== 1'b1) begin n_err++; $display("FAIL rstmid_level v=%0d: got %b expected 1", v, bus.level[0]); end
            bus.raw_in = 3'b000;
            repeat (40) tick();
        end
    endtask

    task automatic test_random();
        int runl [CH] = '{1, 7, 13};
        for (int i = 0; i < 3000; i++) begin
            if (i % 300 == 0) begin
                bus.mode      = 6'($urandom);
                bus.repeat_en = 3'($urandom);
            end
            bus.count_clr = ($urandom_range(0, 40) == 0);
            for (int c = 0; c < CH; c++) begin
                runl[c]--;
                if (runl[c] <= 0) begin
                    bus.raw_in[c] = ~bus.raw_in[c];
                    runl[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 18)) : int'($urandom_range(10, 60));
                end
            end
            if (i == 1500) begin
                set_reset(1'b0);
                tick();
                set_reset(1'b1);
            end
            tick();
            n_cmp++;
            if ({bus.level, bus.pulse, bus.any_pulse, bus.event_count} !== {m_level, m_pulse, |m_pulse, m_count}) begin
                n_err++; $display("FAIL model_random i=%0d: got %h expected %h", i, {bus.level, bus.pulse, bus.any_pulse, bus.event_count}, {m_level, m_pulse, |m_pulse, m_count});
            end
        end
        bus.count_clr = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_press_latency();
        test_glitch();
        test_repeat();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
